// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Sequencing controller for the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline
// registers of a 5-stage MIPS pipeline. It detects load-use hazards and
// inserts LOAD_LAT bubbles, flushes the front of the pipe on a branch taken
// in MEM, and freezes the whole pipe while data memory is busy.
//
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN
//   When defined, stall_cycles / flush_events / freeze_cycles are
//   saturating 32-bit performance counters cleared by reset or perf_clr.
//   When undefined, those outputs are tied to zero and perf_clr is ignored.
//
// State table:
//   state   | meaning
//   RUN     | normal issue; hazard check active
//   STALL   | inserting bubbles 2..LOAD_LAT of a load-use hazard
//   MEMWAIT | data memory busy; pipe frozen, ret_state remembers RUN/STALL
//
// Ports:
//   clk, reset (sync, active-low)
//   id_rs, id_rt, id_uses_rt        source operands of the ID instruction
//   ex_MemRead, ex_rt               load destination currently in ID_EX
//   mem_branch_taken, mem_busy      MEM stage events
//   pc_write, if_id_write           front-end load enables
//   if_id_flush, id_ex_flush,
//   ex_mem_flush, pipe_freeze       pipeline register controls
//   state                           0 RUN, 1 STALL, 2 MEMWAIT
//   perf_clr, stall_cycles,
//   flush_events, freeze_cycles     performance counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int W        = 5,
    parameter int LOAD_LAT = 1,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  id_rs,
    input  logic [W-1:0]  id_rt,
    input  logic          id_uses_rt,
    input  logic          ex_MemRead,
    input  logic [W-1:0]  ex_rt,
    input  logic          mem_branch_taken,
    input  logic          mem_busy,
    output logic          pc_write,
    output logic          if_id_write,
    output logic          if_id_flush,
    output logic          id_ex_flush,
    output logic          ex_mem_flush,
    output logic          pipe_freeze,
    output logic [1:0]    state,
    input  logic          perf_clr,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   flush_events,
    output logic [31:0]   freeze_cycles
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    // Counter preload after the first bubble; only meaningful when LOAD_LAT>1.
    localparam logic [CW-1:0] STALL_INIT = (LOAD_LAT > 1) ? CW'(LOAD_LAT - 2) : '0;

    state_t         state_q, state_d;
    state_t         ret_state_q, ret_state_d;
    logic [CW-1:0]  stall_cnt_q, stall_cnt_d;

    state_t         eff_state;
    logic           hz;
    logic           bubble;
    logic           br_flush;

    assign hz = ex_MemRead && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Leaving MEMWAIT behaves exactly like the state it interrupted.
    assign eff_state = (state_q == MEMWAIT) ? ret_state_q : state_q;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_freeze  = 1'b0;
        bubble       = 1'b0;
        br_flush     = 1'b0;
        state_d      = state_q;
        ret_state_d  = ret_state_q;
        stall_cnt_d  = stall_cnt_q;

        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = RUN;
            ret_state_d  = RUN;
            stall_cnt_d  = '0;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
            if (state_q != MEMWAIT) begin
                ret_state_d = state_q;
            end
            state_d = MEMWAIT;
        end else if (mem_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            br_flush     = 1'b1;
            state_d      = RUN;
            stall_cnt_d  = '0;
        end else if (eff_state == STALL) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            bubble      = 1'b1;
            if (stall_cnt_q == '0) begin
                state_d = RUN;
            end else begin
                state_d     = STALL;
                stall_cnt_d = stall_cnt_q - 1'b1;
            end
        end else if (hz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            bubble      = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d     = STALL;
                stall_cnt_d = STALL_INIT;
            end else begin
                state_d = RUN;
            end
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            ret_state_q <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign state = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cycles_q,  stall_cycles_d;
    logic [31:0] flush_events_q,  flush_events_d;
    logic [31:0] freeze_cycles_q, freeze_cycles_d;

    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        flush_events_d  = flush_events_q;
        freeze_cycles_d = freeze_cycles_q;
        if (perf_clr) begin
            stall_cycles_d  = '0;
            flush_events_d  = '0;
            freeze_cycles_d = '0;
        end else begin
            if (bubble && (stall_cycles_q != '1)) begin
                stall_cycles_d = stall_cycles_q + 32'd1;
            end
            if (br_flush && (flush_events_q != '1)) begin
                flush_events_d = flush_events_q + 32'd1;
            end
            if (pipe_freeze && (freeze_cycles_q != '1)) begin
                freeze_cycles_d = freeze_cycles_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles_q  <= '0;
            flush_events_q  <= '0;
            freeze_cycles_q <= '0;
        end else begin
            stall_cycles_q  <= stall_cycles_d;
            flush_events_q  <= flush_events_d;
            freeze_cycles_q <= freeze_cycles_d;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign flush_events  = flush_events_q;
    assign freeze_cycles = freeze_cycles_q;
`else
    logic [2:0] unused_perf;
    assign unused_perf   = {perf_clr, bubble, br_flush};
    assign stall_cycles  = '0;
    assign flush_events  = '0;
    assign freeze_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_MemRead, mem_branch_taken, mem_busy, perf_clr;

    logic        a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_flush, a_ex_mem_flush, a_pipe_freeze;
    logic [1:0]  a_state;
    logic [31:0] a_stall, a_flush, a_freeze;
    logic        b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_pipe_freeze;
    logic [1:0]  b_state;
    logic [31:0] b_stall, b_flush, b_freeze;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.W(5), .LOAD_LAT(1), .CW(3)) u_lat1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .mem_busy(mem_busy), .pc_write(a_pc_write), .if_id_write(a_if_id_write),
        .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush), .ex_mem_flush(a_ex_mem_flush),
        .pipe_freeze(a_pipe_freeze), .state(a_state), .perf_clr(perf_clr),
        .stall_cycles(a_stall), .flush_events(a_flush), .freeze_cycles(a_freeze)
    );

    pipe_hazard_ctrl #(.W(5), .LOAD_LAT(3), .CW(3)) u_lat3 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .mem_busy(mem_busy), .pc_write(b_pc_write), .if_id_write(b_if_id_write),
        .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush), .ex_mem_flush(b_ex_mem_flush),
        .pipe_freeze(b_pipe_freeze), .state(b_state), .perf_clr(perf_clr),
        .stall_cycles(b_stall), .flush_events(b_flush), .freeze_cycles(b_freeze)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after a falling edge; outputs are checked 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; ex_MemRead = 1'b0;
        mem_branch_taken = 1'b0; mem_busy = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic set_hazard();
        ex_MemRead = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #1;
        checks++;
        if ({b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_pipe_freeze} !== 6'b001110) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=001110",
                     {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_pipe_freeze});
        end
        next_cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (b_state !== 2'd0 || a_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got=%0d/%0d want=0/0", a_state, b_state);
        end
        checks++;
        if ({b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_pipe_freeze} !== 6'b110000) begin
            errors++;
            $display("FAIL idle_defaults got=%b want=110000",
                     {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_pipe_freeze});
        end
        checks++;
        if (b_stall !== 32'd0 || b_flush !== 32'd0 || b_freeze !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf got=%0d,%0d,%0d want=0,0,0", b_stall, b_flush, b_freeze);
        end
        next_cycle();
    endtask

    task automatic test_hazard_lat1();
        apply_reset();
        set_hazard();
        #1;
        checks++;
        if ({a_pc_write, a_if_id_write, a_id_ex_flush} !== 3'b001) begin
            errors++;
            $display("FAIL lat1_bubble got=%b want=001", {a_pc_write, a_if_id_write, a_id_ex_flush});
        end
        next_cycle();
        ex_MemRead = 1'b0;
        #1;
        checks++;
        if (a_state !== 2'd0 || {a_pc_write, a_if_id_write, a_id_ex_flush} !== 3'b110) begin
            errors++;
            $display("FAIL lat1_after state=%0d ctl=%b want state=0 ctl=110",
                     a_state, {a_pc_write, a_if_id_write, a_id_ex_flush});
        end
        next_cycle();
    endtask

    task automatic test_no_hazard();
        apply_reset();
        ex_MemRead = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        checks++;
        if (a_pc_write !== 1'b1 || b_pc_write !== 1'b1) begin
            errors++;
            $display("FAIL rt_zero got=%b%b want=11", a_pc_write, b_pc_write);
        end
        ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        checks++;
        if (a_pc_write !== 1'b1 || b_pc_write !== 1'b1) begin
            errors++;
            $display("FAIL rt_unused got=%b%b want=11", a_pc_write, b_pc_write);
        end
        id_uses_rt = 1'b1;
        #1;
        checks++;
        if (a_pc_write !== 1'b0 || a_id_ex_flush !== 1'b1) begin
            errors++;
            $display("FAIL rt_used got pc=%b bub=%b want pc=0 bub=1", a_pc_write, a_id_ex_flush);
        end
        next_cycle();
    endtask

    task automatic test_lat3();
        logic [1:0] exp_st [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
        logic       exp_bub[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        set_hazard();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (b_state !== exp_st[i] || b_id_ex_flush !== exp_bub[i] || b_pc_write !== !exp_bub[i]) begin
                errors++;
                $display("FAIL lat3_cyc%0d state=%0d bub=%b pc=%b want state=%0d bub=%b",
                         i, b_state, b_id_ex_flush, b_pc_write, exp_st[i], exp_bub[i]);
            end
            next_cycle();
            ex_MemRead = 1'b0;
        end
    endtask

    task automatic test_branch();
        apply_reset();
        set_hazard();
        next_cycle();
        ex_MemRead = 1'b0;
        mem_branch_taken = 1'b1;
        #1;
        checks++;
        if ({b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_pipe_freeze} !== 6'b111110) begin
            errors++;
            $display("FAIL branch_flush got=%b want=111110",
                     {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_pipe_freeze});
        end
        next_cycle();
        mem_branch_taken = 1'b0;
        #1;
        checks++;
        if (b_state !== 2'd0 || {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush} !== 5'b11000) begin
            errors++;
            $display("FAIL branch_after state=%0d ctl=%b want state=0 ctl=11000",
                     b_state, {b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush});
        end
        next_cycle();
    endtask

    task automatic test_memwait();
        logic [1:0] exp_st[4] = '{2'd1, 2'd2, 2'd2, 2'd2};
        apply_reset();
        set_hazard();
        next_cycle();
        ex_MemRead = 1'b0;
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (b_pipe_freeze !== 1'b1 || b_pc_write !== 1'b0 || b_id_ex_flush !== 1'b0 || b_state !== exp_st[i]) begin
                errors++;
                $display("FAIL freeze_cyc%0d frz=%b pc=%b bub=%b state=%0d want frz=1 pc=0 bub=0 state=%0d",
                         i, b_pipe_freeze, b_pc_write, b_id_ex_flush, b_state, exp_st[i]);
            end
            next_cycle();
        end
        mem_busy = 1'b0;
        #1;
        checks++;
        if (b_state !== 2'd2 || b_id_ex_flush !== 1'b1 || b_pipe_freeze !== 1'b0 || b_pc_write !== 1'b0) begin
            errors++;
            $display("FAIL memwait_exit state=%0d bub=%b frz=%b want state=2 bub=1 frz=0",
                     b_state, b_id_ex_flush, b_pipe_freeze);
        end
        next_cycle();
        #1;
        checks++;
        if (b_state !== 2'd1 || b_id_ex_flush !== 1'b1) begin
            errors++;
            $display("FAIL memwait_bub3 state=%0d bub=%b want state=1 bub=1", b_state, b_id_ex_flush);
        end
        next_cycle();
        #1;
        checks++;
        if (b_state !== 2'd0 || b_pc_write !== 1'b1 || b_id_ex_flush !== 1'b0) begin
            errors++;
            $display("FAIL memwait_run state=%0d pc=%b want state=0 pc=1", b_state, b_pc_write);
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        checks++;
        if (b_stall !== 32'd3 || b_freeze !== 32'd4 || b_flush !== 32'd0) begin
            errors++;
            $display("FAIL perf_counts got stall=%0d freeze=%0d flush=%0d want 3,4,0", b_stall, b_freeze, b_flush);
        end
        perf_clr = 1'b1;
        next_cycle();
        perf_clr = 1'b0;
        #1;
        checks++;
        if (b_stall !== 32'd0 || b_freeze !== 32'd0) begin
            errors++;
            $display("FAIL perf_clr got stall=%0d freeze=%0d want 0,0", b_stall, b_freeze);
        end
`else
        checks++;
        if (b_stall !== 32'd0 || b_freeze !== 32'd0 || b_flush !== 32'd0) begin
            errors++;
            $display("FAIL perf_tied got stall=%0d freeze=%0d flush=%0d want 0,0,0", b_stall, b_freeze, b_flush);
        end
`endif
        next_cycle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_hazard();
        next_cycle();
        ex_MemRead = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (b_state !== 2'd1 || {b_pc_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_pipe_freeze} !== 5'b01110) begin
            errors++;
            $display("FAIL reset_mid_outputs state=%0d ctl=%b want state=1 ctl=01110",
                     b_state, {b_pc_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_pipe_freeze});
        end
        next_cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (b_state !== 2'd0 || b_pc_write !== 1'b1 || b_id_ex_flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after state=%0d pc=%b bub=%b want state=0 pc=1 bub=0",
                     b_state, b_pc_write, b_id_ex_flush);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        set_hazard();
        next_cycle();
        ex_MemRead = 1'b0;
        next_cycle();
        next_cycle();
        set_hazard();
        #1;
        checks++;
        if (b_state !== 2'd0 || b_id_ex_flush !== 1'b1 || b_pc_write !== 1'b0) begin
            errors++;
            $display("FAIL b2b_redetect state=%0d bub=%b pc=%b want state=0 bub=1 pc=0",
                     b_state, b_id_ex_flush, b_pc_write);
        end
        next_cycle();
        ex_MemRead = 1'b0;
        #1;
        checks++;
        if (b_state !== 2'd1 || b_id_ex_flush !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stall state=%0d bub=%b want state=1 bub=1", b_state, b_id_ex_flush);
        end
        next_cycle();
    endtask

    task automatic test_priority();
        apply_reset();
        set_hazard();
        mem_busy = 1'b1;
        mem_branch_taken = 1'b1;
        #1;
        checks++;
        if ({b_pc_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_pipe_freeze} !== 5'b00001) begin
            errors++;
            $display("FAIL busy_priority got=%b want=00001",
                     {b_pc_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_pipe_freeze});
        end
        mem_busy = 1'b0;
        #1;
        checks++;
        if ({b_pc_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush} !== 4'b1111) begin
            errors++;
            $display("FAIL branch_over_hz got=%b want=1111",
                     {b_pc_write, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush});
        end
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        next_cycle();
        test_reset();
        test_hazard_lat1();
        test_no_hazard();
        test_lat3();
        test_branch();
        test_memwait();
        test_reset_mid();
        test_back_to_back();
        test_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
